// File: rtl/alu_mul_seq.sv
// Shift-add multiply sequencer that also arbitrates one shared 16-bit ALU.
// CPU requests pass through while idle; a running multiply owns the ALU.
module alu_mul_seq #(
    parameter int DATA_W     = 16,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MUL_START,
    input  logic [DATA_W-1:0] MUL_A,
    input  logic [DATA_W-1:0] MUL_B,
    output logic              MUL_BUSY,
    output logic              MUL_DONE,
    output logic [DATA_W-1:0] MUL_P,
    output logic              MUL_OVF,
    input  logic [DATA_W-1:0] EXT_DA,
    input  logic [DATA_W-1:0] EXT_DB,
    input  logic [2:0]        EXT_CTL,
    input  logic [3:0]        EXT_SHIFT,
    output logic              EXT_GNT,
    output logic [DATA_W-1:0] EXT_DC,
    output logic              EXT_OVF,
    output logic [DATA_W-1:0] ALU_DA,
    output logic [DATA_W-1:0] ALU_DB,
    output logic [2:0]        ALU_CTL,
    output logic [3:0]        ALU_SHIFT,
    input  logic [DATA_W-1:0] ALU_DC,
    input  logic              ALU_OverFlow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_ADD,
        S_DONE
    } state_t;

    localparam logic [2:0] CTL_ADD = 3'b000;
    localparam logic [2:0] CTL_SLL = 3'b100;
    localparam logic [3:0] I_LAST  = 4'(DATA_W - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_tmp;
    logic [3:0]        r_i;
    logic              r_ovf;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_p;
    logic              r_povf;

    logic [DATA_W-1:0] w_hi;
    logic              w_last;
    logic              w_shout;
    logic              w_wrap;

    // Multiplier bits from the current index upward; bit 0 is the bit under test.
    assign w_hi    = r_b >> r_i;
    assign w_last  = (r_i == I_LAST)
                   || (EARLY_EXIT && (w_hi[DATA_W-1:1] == '0));
    assign w_shout = (r_i != 4'd0)
                   && ((r_a >> (DATA_W - int'(r_i))) != '0);
    assign w_wrap  = (ALU_DC < r_acc);

    assign MUL_BUSY = r_busy;
    assign MUL_DONE = r_done;
    assign MUL_P    = r_p;
    assign MUL_OVF  = r_povf;
    assign EXT_GNT  = !r_busy;
    assign EXT_DC   = ALU_DC;
    assign EXT_OVF  = ALU_OverFlow;

    always_comb begin
        ALU_DA    = EXT_DA;
        ALU_DB    = EXT_DB;
        ALU_CTL   = EXT_CTL;
        ALU_SHIFT = EXT_SHIFT;
        case (r_state)
            S_SCAN: begin
                ALU_DA    = r_a;
                ALU_DB    = '0;
                ALU_CTL   = CTL_SLL;
                ALU_SHIFT = r_i;
            end
            S_ADD: begin
                ALU_DA    = r_acc;
                ALU_DB    = r_tmp;
                ALU_CTL   = CTL_ADD;
                ALU_SHIFT = 4'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_tmp   <= '0;
            r_i     <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= '0;
            r_povf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (MUL_START) begin
                        r_a     <= MUL_A;
                        r_b     <= MUL_B;
                        r_acc   <= '0;
                        r_i     <= '0;
                        r_ovf   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (w_hi[0]) begin
                        r_tmp   <= ALU_DC;
                        r_state <= S_ADD;
                        if (w_shout) r_ovf <= 1'b1;
                    end else if (w_last) begin
                        r_p     <= r_acc;
                        r_povf  <= r_ovf;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_i <= r_i + 4'd1;
                    end
                end
                S_ADD: begin
                    // The sum lands in acc and, on the last bit, straight in P.
                    r_acc <= ALU_DC;
                    r_ovf <= r_ovf | w_wrap;
                    if (w_last) begin
                        r_p     <= ALU_DC;
                        r_povf  <= r_ovf | w_wrap;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_i     <= r_i + 4'd1;
                        r_state <= S_SCAN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
